rsa256_stream_host: RTL and testbench
=====================================

RSA256_STREAM_HOST -- requirements
Module: rsa256_stream_host

Interface
REQ-001 Parameter: TX_BYTES, default 31, number of result bytes returned per block (MSB first, from result bit 8*TX_BYTES-1 down to bit 0); legal range 1..32.
REQ-002 i_clk  in  1  single clock; all state changes on rising edge.
REQ-003 i_rst_n  in  1  reset, asynchronous and active-low.
REQ-004 i_rx_data  in  8  incoming byte.
REQ-005 i_rx_valid  in  1  i_rx_data valid.
REQ-006 o_rx_ready  out  1  block accepts a byte; a byte transfers on an edge where i_rx_valid and o_rx_ready are both 1.
REQ-007 o_tx_data  out  8  outgoing byte.
REQ-008 o_tx_valid  out  1  o_tx_data valid.
REQ-009 i_tx_ready  in  1  sink accepts; a byte transfers on an edge where o_tx_valid and i_tx_ready are both 1.
REQ-010 o_core_n, o_core_d, o_core_a  out  256 each  modulus, private exponent and ciphertext presented to the RSA core.
REQ-011 o_core_start  out  1  single-cycle start pulse to the core.
REQ-012 i_core_result  in  256  core output a^d mod n.
REQ-013 i_core_finished  in  1  core done pulse; i_core_result valid in the same cycle.
REQ-014 o_busy  out  1  high in S_START and S_WAIT.

Function
REQ-015 States: S_GET_N, S_GET_D, S_GET_A, S_START, S_WAIT, S_SEND.
REQ-016 o_rx_ready is 1 exactly in S_GET_N, S_GET_D and S_GET_A. It is 0 in all other states.
REQ-017 In each S_GET_* state, every accepted byte shifts into the target register: reg <= {reg[247:0], i_rx_data}. The first byte is therefore the MSB.
REQ-018 A 5-bit byte counter increments on each accepted byte and wraps from 31 to 0. On the 32nd byte the state advances: S_GET_N->S_GET_D, S_GET_D->S_GET_A, S_GET_A->S_START.
REQ-019 S_START lasts exactly one cycle. In that cycle o_core_start=1, then the state goes to S_WAIT.
REQ-020 o_core_n, o_core_d and o_core_a are driven from the registers continuously. They do not change in S_START or S_WAIT.
REQ-021 In S_WAIT, when i_core_finished=1, i_core_result is latched into the tx shift register and the state goes to S_SEND. i_core_finished is ignored in every other state.
REQ-022 In S_SEND, o_tx_valid=1 and o_tx_data = txreg[8*TX_BYTES-1 -: 8].
- On each transfer, txreg shifts left by 8 and the tx counter increments.
- After transfer number TX_BYTES, o_tx_valid drops on the next cycle and the state goes to S_GET_A.
- n and d are retained, so only the ciphertext is reloaded for following blocks.
REQ-023 While o_tx_valid=1 and i_tx_ready=0, o_tx_data and o_tx_valid stay stable.
REQ-024 Latency:
- o_core_start is asserted the cycle after the edge that accepts the 96th byte (first block) or the 32nd ciphertext byte (later blocks).
- o_tx_valid rises the cycle after the edge that samples i_core_finished=1.
REQ-025 i_rx_valid in states where o_rx_ready=0 is ignored, and no byte is consumed.
REQ-026 The output side (o_tx_valid, o_tx_data) and the input side never transfer in the same cycle, because S_SEND and S_GET_* are exclusive.

Reset
REQ-027 When i_rst_n=0, asynchronously and regardless of state:
- state goes to S_GET_N;
- both counters go to 0;
- the n, d, a and tx registers go to 0;
- o_rx_ready, o_tx_valid, o_core_start and o_busy go to 0;
- o_tx_data goes to 0.
REQ-028 A reset during S_WAIT or S_SEND discards the block and requires a fresh key load. A core pulse still in flight after reset is ignored per REQ-021.

Verification
REQ-029 Full block, with a behavioural core that returns 6:
- Stimulus: n = 31x00 then 0x0D; d = 31x00 then 0x05; a = 31x00 then 0x02.
- Required: o_core_n=13, o_core_d=5, o_core_a=2; one o_core_start pulse one cycle after the 96th byte; o_busy=1 until finish.
- Required on tx: 30x00 then 0x06 (TX_BYTES=31), then state returns to S_GET_A.
REQ-030 Second block without rekey: 32 bytes with a=3 -> o_core_n and o_core_d unchanged (13, 5); start pulse after the 32nd byte.
REQ-031 Tx backpressure: hold i_tx_ready=0 for 5 cycles on byte 10 -> o_tx_data stays constant and o_tx_valid stays 1; the full byte sequence is unchanged with no duplicates or drops.
REQ-032 Rx gaps: i_rx_valid toggles 1,0,0,1,... -> only valid-qualified bytes are counted and register contents match the gapless case.
REQ-033 Spurious events:
- i_core_finished pulse in S_GET_A, and i_rx_valid=1 during S_WAIT -> no state change and no byte consumed.
REQ-034 Reset mid-operation:
- Assert i_rst_n=0 in S_SEND after 4 bytes -> all outputs go to 0 immediately.
- After release, the block waits in S_GET_N with o_rx_ready=1.

Source files
------------

// File: rtl/rsa256_stream_host.sv
// Byte-stream host for a 256-bit RSA core: loads n, d and a MSB-first, starts the core,
// then streams the low TX_BYTES bytes of the result MSB-first.
module rsa256_stream_host #(
    parameter int TX_BYTES = 31
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [7:0]   i_rx_data,
    input  logic         i_rx_valid,
    output logic         o_rx_ready,
    output logic [7:0]   o_tx_data,
    output logic         o_tx_valid,
    input  logic         i_tx_ready,
    output logic [255:0] o_core_n,
    output logic [255:0] o_core_d,
    output logic [255:0] o_core_a,
    output logic         o_core_start,
    input  logic [255:0] i_core_result,
    input  logic         i_core_finished,
    output logic         o_busy
);

    localparam logic [2:0] S_GET_N = 3'd0;
    localparam logic [2:0] S_GET_D = 3'd1;
    localparam logic [2:0] S_GET_A = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_SEND  = 3'd5;

    localparam logic [4:0] TX_LAST = 5'(TX_BYTES - 1);

    logic [2:0]   state_q, state_d;
    logic [4:0]   rx_cnt_q, rx_cnt_d;
    logic [4:0]   tx_cnt_q, tx_cnt_d;
    logic [255:0] n_q, n_d;
    logic [255:0] d_q, d_d;
    logic [255:0] a_q, a_d;
    logic [255:0] tx_q, tx_d;
    logic         rx_fire;
    logic         tx_fire;

    // Ready is masked by reset so the block advertises nothing while held in reset.
    assign o_rx_ready   = i_rst_n & ((state_q == S_GET_N) | (state_q == S_GET_D) |
                                     (state_q == S_GET_A));
    assign o_tx_valid   = (state_q == S_SEND);
    assign o_core_start = (state_q == S_START);
    assign o_busy       = (state_q == S_START) | (state_q == S_WAIT);
    assign o_tx_data    = tx_q[8*TX_BYTES-1 -: 8];
    assign o_core_n     = n_q;
    assign o_core_d     = d_q;
    assign o_core_a     = a_q;

    assign rx_fire = o_rx_ready & i_rx_valid;
    assign tx_fire = o_tx_valid & i_tx_ready;

    always_comb begin
        state_d  = state_q;
        rx_cnt_d = rx_cnt_q;
        tx_cnt_d = tx_cnt_q;
        n_d      = n_q;
        d_d      = d_q;
        a_d      = a_q;
        tx_d     = tx_q;
        case (state_q)
            S_GET_N: begin
                if (rx_fire) begin
                    n_d      = {n_q[247:0], i_rx_data};
                    rx_cnt_d = rx_cnt_q + 5'd1;
                    if (rx_cnt_q == 5'd31) state_d = S_GET_D;
                end
            end
            S_GET_D: begin
                if (rx_fire) begin
                    d_d      = {d_q[247:0], i_rx_data};
                    rx_cnt_d = rx_cnt_q + 5'd1;
                    if (rx_cnt_q == 5'd31) state_d = S_GET_A;
                end
            end
            S_GET_A: begin
                if (rx_fire) begin
                    a_d      = {a_q[247:0], i_rx_data};
                    rx_cnt_d = rx_cnt_q + 5'd1;
                    if (rx_cnt_q == 5'd31) state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_core_finished) begin
                    tx_d    = i_core_result;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                // Key registers stay loaded, so the next block only needs a new ciphertext.
                if (tx_fire) begin
                    tx_d     = {tx_q[247:0], 8'h00};
                    tx_cnt_d = tx_cnt_q + 5'd1;
                    if (tx_cnt_q == TX_LAST) begin
                        tx_cnt_d = 5'd0;
                        state_d  = S_GET_A;
                    end
                end
            end
            default: begin
                state_d = S_GET_N;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_GET_N;
            rx_cnt_q <= 5'd0;
            tx_cnt_q <= 5'd0;
            n_q      <= '0;
            d_q      <= '0;
            a_q      <= '0;
            tx_q     <= '0;
        end else begin
            state_q  <= state_d;
            rx_cnt_q <= rx_cnt_d;
            tx_cnt_q <= tx_cnt_d;
            n_q      <= n_d;
            d_q      <= d_d;
            a_q      <= a_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: tb/tb_rsa256_stream_host.sv
// Self-checking bench for rsa256_stream_host with a behavioural modular-exponentiation core.
module tb_rsa256_stream_host;

    localparam int TXB = 31;

    logic         clk;
    logic         i_rst_n;
    logic [7:0]   i_rx_data;
    logic         i_rx_valid;
    logic         o_rx_ready;
    logic [7:0]   o_tx_data;
    logic         o_tx_valid;
    logic         i_tx_ready;
    logic [255:0] o_core_n, o_core_d, o_core_a;
    logic         o_core_start;
    logic [255:0] core_res;
    logic         core_fin, spur_fin;
    logic         o_busy;

    rsa256_stream_host #(.TX_BYTES(TXB)) dut (
        .i_clk          (clk),
        .i_rst_n        (i_rst_n),
        .i_rx_data      (i_rx_data),
        .i_rx_valid     (i_rx_valid),
        .o_rx_ready     (o_rx_ready),
        .o_tx_data      (o_tx_data),
        .o_tx_valid     (o_tx_valid),
        .i_tx_ready     (i_tx_ready),
        .o_core_n       (o_core_n),
        .o_core_d       (o_core_d),
        .o_core_a       (o_core_a),
        .o_core_start   (o_core_start),
        .i_core_result  (core_res),
        .i_core_finished(core_fin | spur_fin),
        .o_busy         (o_busy)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] got_q[$];
    int start_cnt = 0;
    int busy_cyc = 0;
    int stall_cyc = 0;
    int ready_mode = 0;
    int hold = 0;
    int core_delay = 3;
    bit lat_chk = 1;
    bit prev_stall = 0;
    logic [7:0] prev_data = 8'h00;

    typedef struct {
        logic [255:0] a;
        int           gap;
        int           dly;
        int           bp;
        logic [255:0] exp;
    } vec_t;
    vec_t tbl[6];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, got, exp);
        end
    endtask

    function automatic logic [255:0] modexp(input logic [255:0] a, input logic [255:0] d,
                                            input logic [255:0] n);
        logic [511:0] r, b, m;
        if (n == 256'd0) return 256'd0;
        m = {256'd0, n};
        r = 512'd1 % m;
        b = {256'd0, a} % m;
        for (int i = 0; i < 256; i++) begin
            if (d[i]) r = (r * b) % m;
            b = (b * b) % m;
        end
        return r[255:0];
    endfunction

    // Behavioural RSA core: latch operands on start, answer after core_delay cycles.
    initial begin
        logic [255:0] res;
        core_fin = 1'b0;
        core_res = '0;
        forever begin
            @(negedge clk);
            if (o_core_start) begin
                res = modexp(o_core_a, o_core_d, o_core_n);
                repeat (core_delay) @(negedge clk);
                core_fin = 1'b1;
                core_res = res;
                @(negedge clk);
                core_fin = 1'b0;
                if (lat_chk) chk("tx_valid_latency", o_tx_valid, 1);
            end
        end
    end

    initial begin
        i_tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: i_tx_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (o_tx_valid && got_q.size() == 9 && hold < 5) begin
                        i_tx_ready = 1'b0;
                        hold++;
                    end else begin
                        i_tx_ready = 1'b1;
                    end
                end
                default: i_tx_ready = 1'b1;
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (prev_stall) chk("tx_hold", {o_tx_valid, o_tx_data}, {1'b1, prev_data});
            if (o_tx_valid && i_tx_ready) got_q.push_back(o_tx_data);
            if (o_tx_valid && !i_tx_ready) stall_cyc++;
            prev_stall = o_tx_valid && !i_tx_ready && i_rst_n;
            prev_data  = o_tx_data;
            if (o_core_start) start_cnt++;
            if (o_busy) busy_cyc++;
        end
    end

    task automatic rx_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        t = 0;
        while (!o_rx_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!o_rx_ready) chk("rx_timeout", o_rx_ready, 1);
        @(posedge clk);
        #1 i_rx_valid = 1'b0;
    endtask

    task automatic load_key(input logic [255:0] n, input logic [255:0] d, input int gap);
        for (int i = 0; i < 32; i++) rx_byte(n[255-8*i -: 8], gap);
        for (int i = 0; i < 32; i++) rx_byte(d[255-8*i -: 8], gap);
        @(negedge clk);
        chk("key_n", o_core_n, n);
        chk("key_d", o_core_d, d);
        chk("key_rx_ready", o_rx_ready, 1);
    endtask

    task automatic send_a(input logic [255:0] a, input int gap);
        got_q.delete();
        for (int i = 0; i < 32; i++) rx_byte(a[255-8*i -: 8], gap);
        @(negedge clk);
        chk("start_pulse", o_core_start, 1);
        chk("busy_at_start", o_busy, 1);
        chk("core_a", o_core_a, a);
    endtask

    task automatic finish_block(input string nm, input logic [255:0] exp);
        int t;
        t = 0;
        while (got_q.size() < TXB && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (got_q.size() < TXB) chk({nm, "_tx_timeout"}, got_q.size(), TXB);
        @(negedge clk);
        chk({nm, "_tx_count"}, got_q.size(), TXB);
        for (int i = 0; i < TXB && i < got_q.size(); i++)
            chk($sformatf("%s_byte%0d", nm, i), got_q[i], exp[8*(TXB-1-i) +: 8]);
        chk({nm, "_valid_drop"}, o_tx_valid, 0);
        chk({nm, "_back_to_rx"}, o_rx_ready, 1);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_rx_ready"}, o_rx_ready, 0);
        chk({nm, "_tx_valid"}, o_tx_valid, 0);
        chk({nm, "_tx_data"}, o_tx_data, 0);
        chk({nm, "_start"}, o_core_start, 0);
        chk({nm, "_busy"}, o_busy, 0);
        chk({nm, "_core_nda"}, o_core_n | o_core_d | o_core_a, 0);
    endtask

    initial begin
        int st0, b0, s0, t, vcnt;
        logic [255:0] rn, rd, ra;

        tbl[0] = '{a: 256'd2,  gap: 0, dly: 3, bp: 0, exp: 256'd6};
        tbl[1] = '{a: 256'd3,  gap: 0, dly: 1, bp: 0, exp: 256'd9};
        tbl[2] = '{a: 256'd4,  gap: 2, dly: 5, bp: 0, exp: 256'd10};
        tbl[3] = '{a: 256'd12, gap: 1, dly: 2, bp: 1, exp: 256'd12};
        tbl[4] = '{a: 256'd0,  gap: 0, dly: 4, bp: 0, exp: 256'd0};
        tbl[5] = '{a: 256'd7,  gap: 0, dly: 2, bp: 0, exp: 256'd11};

        i_rst_n    = 1'b0;
        i_rx_data  = 8'h00;
        i_rx_valid = 1'b0;
        spur_fin   = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        i_rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_rx_ready", o_rx_ready, 1);
        chk("post_reset_busy", o_busy, 0);

        load_key(256'd13, 256'd5, 0);
        for (int k = 0; k < 6; k++) begin
            core_delay = tbl[k].dly;
            ready_mode = tbl[k].bp ? 2 : 0;
            hold = 0;
            st0 = start_cnt;
            b0 = busy_cyc;
            s0 = stall_cyc;
            send_a(tbl[k].a, tbl[k].gap);
            finish_block($sformatf("tbl%0d", k), tbl[k].exp);
            chk($sformatf("tbl%0d_one_start", k), start_cnt - st0, 1);
            chk($sformatf("tbl%0d_busy_cycles", k), busy_cyc - b0, tbl[k].dly + 1);
            chk($sformatf("tbl%0d_n_kept", k), o_core_n, 13);
            chk($sformatf("tbl%0d_d_kept", k), o_core_d, 5);
            if (tbl[k].bp) chk("bp_stall_cycles", stall_cyc - s0, 5);
        end
        ready_mode = 0;

        // Spurious core pulse while waiting for ciphertext.
        @(negedge clk);
        spur_fin = 1'b1;
        @(negedge clk);
        spur_fin = 1'b0;
        chk("spur_fin_tx_valid", o_tx_valid, 0);
        chk("spur_fin_rx_ready", o_rx_ready, 1);
        chk("spur_fin_busy", o_busy, 0);

        // Rx valid held during WAIT must not be consumed.
        core_delay = 12;
        b0 = busy_cyc;
        send_a(256'd6, 0);
        vcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            i_rx_data  = 8'hAA;
            i_rx_valid = 1'b1;
            if (o_rx_ready || !o_busy) vcnt++;
        end
        chk("wait_rx_ignored", vcnt, 0);
        chk("wait_core_a_kept", o_core_a, 6);
        i_rx_valid = 1'b0;
        finish_block("spur_rx", 256'd2);
        chk("spur_rx_busy_cycles", busy_cyc - b0, 13);

        // Random key and ciphertexts against the reference model.
        for (int w = 0; w < 8; w++) begin
            rn[32*w +: 32] = $urandom;
            rd[32*w +: 32] = $urandom;
        end
        rn[255] = 1'b1;
        i_rst_n = 1'b0;
        @(negedge clk);
        i_rst_n = 1'b1;
        load_key(rn, rd, 1);
        ready_mode = 1;
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 8; w++) ra[32*w +: 32] = $urandom;
            core_delay = int'($urandom_range(1, 8));
            st0 = start_cnt;
            send_a(ra, int'($urandom_range(0, 2)));
            finish_block($sformatf("rnd%0d", k), modexp(ra, rd, rn));
            chk($sformatf("rnd%0d_one_start", k), start_cnt - st0, 1);
        end
        ready_mode = 0;

        // Reset in the middle of SEND.
        i_rst_n = 1'b0;
        @(negedge clk);
        i_rst_n = 1'b1;
        load_key(256'd13, 256'd5, 0);
        core_delay = 2;
        send_a(256'd2, 0);
        t = 0;
        while (got_q.size() < 4 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("send_reached_4", got_q.size() >= 4, 1);
        @(posedge clk);
        #2 i_rst_n = 1'b0;
        #1;
        check_reset_outputs("send_reset");
        @(negedge clk);
        i_rst_n = 1'b1;
        @(negedge clk);
        chk("send_reset_rx_ready", o_rx_ready, 1);
        chk("send_reset_tx_valid", o_tx_valid, 0);

        // Reset during WAIT while a core pulse is still in flight.
        load_key(256'd13, 256'd5, 0);
        core_delay = 10;
        lat_chk = 0;
        send_a(256'd2, 0);
        repeat (2) @(negedge clk);
        i_rst_n = 1'b0;
        #1;
        check_reset_outputs("wait_reset");
        @(negedge clk);
        i_rst_n = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_tx_valid || o_busy || !o_rx_ready) vcnt++;
        end
        chk("inflight_fin_ignored", vcnt, 0);
        lat_chk = 1;

        load_key(256'd13, 256'd5, 0);
        core_delay = 3;
        send_a(256'd3, 0);
        finish_block("rekey", 256'd9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not complete, checks %0d", checks);
        $fatal(1, "timeout");
    end

endmodule
